// File: rtl/fcn_exhaustive_bist_seq_if.sv
// Bus between the test controller, the network under test and the BIST sequencer.
// Optional golden-check ports exist only when FCN_BIST_GOLDEN_CHECK_EN is defined.
interface fcn_exhaustive_bist_seq_if #(
  parameter int unsigned NUM_PI = 5,
  parameter int unsigned NUM_PO = 2,
  parameter int unsigned SIG_W  = 16
);
  logic              start_i;
  logic [SIG_W-1:0]  expected_sig_i;
  logic [NUM_PO-1:0] dut_po_i;
  logic [NUM_PI-1:0] dut_pi_o;
  logic              busy_o;
  logic              done_o;
  logic              pass_o;
  logic [SIG_W-1:0]  signature_o;
`ifdef FCN_BIST_GOLDEN_CHECK_EN
  logic              fail_seen_o;
  logic [NUM_PI-1:0] first_fail_vec_o;

  modport master (
    output start_i, expected_sig_i, dut_po_i,
    input  dut_pi_o, busy_o, done_o, pass_o, signature_o, fail_seen_o, first_fail_vec_o
  );
  modport slave (
    input  start_i, expected_sig_i, dut_po_i,
    output dut_pi_o, busy_o, done_o, pass_o, signature_o, fail_seen_o, first_fail_vec_o
  );
`else
  modport master (
    output start_i, expected_sig_i, dut_po_i,
    input  dut_pi_o, busy_o, done_o, pass_o, signature_o
  );
  modport slave (
    input  start_i, expected_sig_i, dut_po_i,
    output dut_pi_o, busy_o, done_o, pass_o, signature_o
  );
`endif
endinterface

// File: rtl/fcn_exhaustive_bist_seq.sv
// Exhaustive BIST sequencer: applies every input vector to a small logic network,
// compacts the delayed outputs into a MISR and compares against a golden signature.
// Optional macro FCN_BIST_GOLDEN_CHECK_EN adds a per-vector golden model
// (only valid for NUM_PI=5, NUM_PO=2) with first-failing-vector capture.
module fcn_exhaustive_bist_seq #(
  parameter int unsigned       NUM_PI   = 5,
  parameter int unsigned       NUM_PO   = 2,
  parameter int unsigned       LATENCY  = 4,
  parameter int unsigned       SIG_W    = 16,
  parameter logic [SIG_W-1:0]  SIG_POLY = 16'h1021,
  parameter logic [SIG_W-1:0]  SIG_SEED = 16'hFFFF
) (
  input logic                    clk,
  input logic                    rst_n,
  fcn_exhaustive_bist_seq_if.slave bus
);

  localparam int unsigned PIPE_D     = (LATENCY == 0) ? 1 : LATENCY;
  localparam int unsigned DRAIN_W    = $clog2(LATENCY + 1);
  localparam int unsigned CNT_W      = (NUM_PI + 1 > DRAIN_W) ? NUM_PI + 1 : DRAIN_W;
  localparam int unsigned DRAIN_LAST = (LATENCY == 0) ? 0 : LATENCY - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_PI-1:0] pi_q, pi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic [PIPE_D-1:0] vld_q, vld_d;

  logic              apply_c;
  logic              capture_c;
  logic              start_acc_c;
  logic              pass_ok_c;
  logic [SIG_W-1:0]  misr_c;

  assign apply_c     = (state_q == S_APPLY);
  assign capture_c   = (LATENCY == 0) ? apply_c : vld_q[PIPE_D-1];
  assign start_acc_c = (state_q == S_IDLE) && bus.start_i;
  assign misr_c      = {sig_q[SIG_W-2:0], 1'b0}
                     ^ (sig_q[SIG_W-1] ? SIG_POLY : '0)
                     ^ SIG_W'(bus.dut_po_i);

`ifdef FCN_BIST_GOLDEN_CHECK_EN
  localparam int unsigned VEC_PIPE_W = PIPE_D * NUM_PI;

  logic [PIPE_D-1:0][NUM_PI-1:0] vec_q, vec_d;
  logic                          fail_seen_q, fail_seen_d;
  logic [NUM_PI-1:0]             first_fail_vec_q, first_fail_vec_d;
  logic [NUM_PI-1:0]             vec_dly_c;
  logic [1:0]                    gold_c;
  logic                          mismatch_c;

  assign vec_dly_c  = (LATENCY == 0) ? pi_q : vec_q[PIPE_D-1];
  assign gold_c[0]  = (vec_dly_c[1] & ~(vec_dly_c[2] & vec_dly_c[3])) | (vec_dly_c[0] & vec_dly_c[2]);
  assign gold_c[1]  = ~(vec_dly_c[2] & vec_dly_c[3]) & (vec_dly_c[1] | vec_dly_c[4]);
  assign mismatch_c = capture_c && (bus.dut_po_i != gold_c);
  assign pass_ok_c  = (sig_q == bus.expected_sig_i) && !fail_seen_q;

  // Golden-model bookkeeping: vector delay line and first-failure latch
  always_comb begin
    vec_d            = VEC_PIPE_W'({vec_q, pi_q});
    fail_seen_d      = fail_seen_q;
    first_fail_vec_d = first_fail_vec_q;
    if (start_acc_c) begin
      fail_seen_d      = 1'b0;
      first_fail_vec_d = '0;
    end else if (mismatch_c && !fail_seen_q) begin
      fail_seen_d      = 1'b1;
      first_fail_vec_d = vec_dly_c;
    end
  end

  // Golden-model registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_q            <= '0;
      fail_seen_q      <= 1'b0;
      first_fail_vec_q <= '0;
    end else begin
      vec_q            <= vec_d;
      fail_seen_q      <= fail_seen_d;
      first_fail_vec_q <= first_fail_vec_d;
    end
  end

  assign bus.fail_seen_o      = fail_seen_q;
  assign bus.first_fail_vec_o = first_fail_vec_q;
`else
  assign pass_ok_c = (sig_q == bus.expected_sig_i);
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start_i) state_d = S_APPLY;
      S_APPLY: if (cnt_q[NUM_PI]) state_d = (LATENCY == 0) ? S_DONE : S_DRAIN;
      S_DRAIN: if (cnt_q == CNT_W'(DRAIN_LAST)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; cnt_q counts vectors applied, then drain cycles
  always_comb begin
    cnt_d  = cnt_q;
    pi_d   = pi_q;
    pass_d = pass_q;
    sig_d  = sig_q;
    vld_d  = PIPE_D'({vld_q, apply_c});
    busy_d = (state_d == S_APPLY) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    if (capture_c) sig_d = misr_c;
    case (state_q)
      S_IDLE: begin
        pi_d = '0;
        if (bus.start_i) begin
          cnt_d  = CNT_W'(1);
          sig_d  = SIG_SEED;
          pass_d = 1'b0;
        end
      end
      S_APPLY: begin
        if (cnt_q[NUM_PI]) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          pi_d  = pi_q + NUM_PI'(1);
        end
      end
      S_DRAIN: cnt_d = cnt_q + CNT_W'(1);
      S_DONE: begin
        pi_d   = '0;
        pass_d = pass_ok_c;
      end
      default: pi_d = '0;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pi_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      sig_q  <= SIG_SEED;
      vld_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pi_q   <= pi_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      sig_q  <= sig_d;
      vld_q  <= vld_d;
    end
  end

  assign bus.dut_pi_o    = pi_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.pass_o      = pass_q;
  assign bus.signature_o = sig_q;

endmodule

// File: doc/fcn_exhaustive_bist_seq.md
Name: fcn_exhaustive_bist_seq

Overview:
- Built-in self-test sequencer for a small combinational logic network, such as a 5-input/2-output benchmark mapped onto clock-zoned FCN layout.
- Applies every input vector 0..2^NUM_PI-1 in ascending order and absorbs the network outputs into a MISR signature after a fixed pipeline latency.
- Compares the final signature against a supplied golden value.
- Sits between the test controller (start/done handshake) and the network under test.

Parameters:
- NUM_PI, 5, network input width; vector count = 2^NUM_PI.
- NUM_PO, 2, network output width; must satisfy NUM_PO <= SIG_W.
- LATENCY, 4, cycles from applying a vector on dut_pi_o to its result on dut_po_i (clock-zone depth). 0 = purely combinational.
- SIG_W, 16, MISR width.
- SIG_POLY, 16'h1021, MISR feedback polynomial.
- SIG_SEED, 16'hFFFF, MISR initial value.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start_i  in  1  run request, sampled only in IDLE.
- expected_sig_i  in  SIG_W  golden signature, sampled in DONE.
- dut_po_i  in  NUM_PO  outputs of the network under test.
- dut_pi_o  out  NUM_PI  input vector driven to the network.
- busy_o  out  1  high in APPLY and DRAIN.
- done_o  out  1  one-cycle completion pulse.
- pass_o  out  1  result of the last run; held until the next accepted start.
- signature_o  out  SIG_W  current MISR value.

Behaviour:
- Reset (rst_n low at an edge):
  - state IDLE; dut_pi_o=0, busy_o=0, done_o=0, pass_o=0, signature_o=SIG_SEED; valid pipe cleared.
  - A mid-run reset aborts the run with no done_o pulse.
- FSM states: IDLE, APPLY, DRAIN, DONE.
- IDLE:
  - dut_pi_o=0.
  - start_i high at edge k -> APPLY from cycle k+1; MISR loaded with SIG_SEED; pass_o cleared.
- APPLY:
  - Lasts exactly 2^NUM_PI cycles: k+1..k+2^NUM_PI. dut_pi_o = 0,1,..,2^NUM_PI-1, incrementing each cycle.
  - The vector counter is NUM_PI+1 bits so the terminal condition is detected without wrap ambiguity.
  - Each applied vector pushes a 1 into a LATENCY-deep valid shift register.
- DRAIN:
  - Lasts LATENCY cycles; dut_pi_o holds the last vector; the valid pipe shifts in 0.
  - Skipped entirely when LATENCY=0.
- Capture:
  - When the valid pipe output is high, the MISR absorbs dut_po_i at that edge.
  - The vector applied in cycle c is captured at the end of cycle c+LATENCY.
  - Exactly 2^NUM_PI absorptions per run.
- MISR update: sig <= (sig<<1) ^ (sig[SIG_W-1] ? SIG_POLY : 0) ^ zero_extend(dut_po_i).
- DONE:
  - One cycle, k+2^NUM_PI+LATENCY+1; done_o=1; pass_o <= (signature == expected_sig_i).
  - Next cycle returns to IDLE with dut_pi_o=0.
- Handshake:
  - start_i is ignored in APPLY, DRAIN and DONE.
  - If start_i is held high, a new run is accepted on the first IDLE cycle after DONE; back-to-back runs are separated by one IDLE cycle.
- signature_o is valid at all times; it is final from the DONE cycle until the next accepted start.

Optional Feature:
- Macro: FCN_BIST_GOLDEN_CHECK_EN (legal only with NUM_PI=5, NUM_PO=2).
- When defined:
  - The block contains a per-vector golden model: po0 = (pi1 & ~(pi2&pi3)) | (pi0&pi2); po1 = ~(pi2&pi3) & (pi1|pi4).
  - The golden result is computed on the vector delayed LATENCY cycles and compared at each capture.
  - Extra ports: fail_seen_o (1 bit) and first_fail_vec_o (NUM_PI bits), both cleared on reset and on an accepted start.
  - First mismatch sets fail_seen_o and latches the vector; later mismatches do not overwrite it.
  - In DONE: pass_o = signature match AND !fail_seen_o.
- When undefined: no extra ports; pass_o depends on the signature match only.

Test Plan:
- Reset: rst_n low for 3 cycles -> busy_o=0, done_o=0, pass_o=0, dut_pi_o=0, signature_o=16'hFFFF.
- Good run, LATENCY=4, bench DUT model with 4-stage delay, expected_sig_i from bench MISR model; start_i pulse at edge 10:
  - dut_pi_o = 0..31 on cycles 11..42; busy_o high on cycles 11..46.
  - done_o high on cycle 47 only; pass_o=1.
- Fault run: DUT po1 stuck-at-0, same expected_sig_i -> done_o on cycle 47, pass_o=0, signature_o differs from expected_sig_i.
- LATENCY=0 and start_i held high continuously:
  - Runs at cycles k+1..k+32 and DONE at k+33.
  - Next run applies vector 0 at k+35; start_i pulses during busy have no effect.
- Reset mid-run: rst_n low at the edge while dut_pi_o=17 -> next cycle IDLE, all outputs at reset values, no done_o pulse; a subsequent start runs a full 32 vectors.
- With FCN_BIST_GOLDEN_CHECK_EN defined: flip po0 only for vector 9, also flip for vector 20 -> fail_seen_o=1, first_fail_vec_o=9, pass_o=0 at DONE.
